// File: rtl/alu_seq_pkg.sv
// alu_seq shared opcodes, FSM states and op classification.
// ALU_SEQ_DIV_EN adds the DIVU/REMU iterative ops.
package alu_seq_pkg;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_NOR  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_MUL  = 4'b1000;
   localparam logic [3:0] OP_DIVU = 4'b1010;
   localparam logic [3:0] OP_REMU = 4'b1011;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   function automatic logic is_iter(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
      return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
`else
      return (op == OP_MUL);
`endif
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq operand/result handshake bundle.
// master drives operands and result-ready; slave is the ALU.
interface alu_seq_if #(
   parameter int WIDTH = 32
);
   logic             valid_i;
   logic             ready_o;
   logic [WIDTH-1:0] src1_i;
   logic [WIDTH-1:0] src2_i;
   logic [3:0]       ctrl_i;
   logic             valid_o;
   logic             ready_i;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;

   modport master (
      output valid_i, src1_i, src2_i, ctrl_i, ready_i,
      input  ready_o, valid_o, result_o, zero_o
   );

   modport slave (
      input  valid_i, src1_i, src2_i, ctrl_i, ready_i,
      output ready_o, valid_o, result_o, zero_o
   );
endinterface

// File: rtl/alu_seq_iter.sv
// alu_seq iterative datapath: shift-add multiply, one bit per cycle.
// ALU_SEQ_DIV_EN adds a restoring divider sharing the same registers.
module alu_seq_iter
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
`ifdef ALU_SEQ_DIV_EN
   input  logic [3:0]       op_i,
`endif
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] res_o
);

   localparam int CW = $clog2(WIDTH);

   logic             run_q, run_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
`ifdef ALU_SEQ_DIV_EN
   logic             div_q, div_d;
   logic             rem_q, rem_d;
   logic [WIDTH:0]   sh;
   logic [WIDTH:0]   df;
`endif

   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      opa_d = opa_q;
      opb_d = opb_q;
`ifdef ALU_SEQ_DIV_EN
      div_d = div_q;
      rem_d = rem_q;
      sh    = '0;
      df    = '0;
`endif
      if (start_i) begin
         run_d = 1'b1;
         cnt_d = CW'(WIDTH - 1);
         acc_d = '0;
         opa_d = a_i;
         opb_d = b_i;
`ifdef ALU_SEQ_DIV_EN
         div_d = (op_i != OP_MUL);
         rem_d = (op_i == OP_REMU);
`endif
      end else if (run_q) begin
         run_d = (cnt_q != '0);
         cnt_d = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
`ifdef ALU_SEQ_DIV_EN
         if (div_q) begin
            // acc holds the partial remainder, opa shifts dividend out and quotient in
            sh = {acc_q, opa_q[WIDTH-1]};
            df = sh - {1'b0, opb_q};
            if (sh >= {1'b0, opb_q}) begin
               acc_d = df[WIDTH-1:0];
               opa_d = {opa_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = sh[WIDTH-1:0];
               opa_d = {opa_q[WIDTH-2:0], 1'b0};
            end
         end else begin
`endif
            if (opb_q[0]) acc_d = acc_q + opa_q;
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
`ifdef ALU_SEQ_DIV_EN
         end
`endif
      end
   end

   assign done_o = run_q && (cnt_q == '0);

`ifdef ALU_SEQ_DIV_EN
   assign res_o = (div_q && !rem_q) ? opa_d : acc_d;
`else
   assign res_o = acc_d;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_q <= 1'b0;
         cnt_q <= '0;
         acc_q <= '0;
         opa_q <= '0;
         opb_q <= '0;
`ifdef ALU_SEQ_DIV_EN
         div_q <= 1'b0;
         rem_q <= 1'b0;
`endif
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
         opa_q <= opa_d;
         opb_q <= opb_d;
`ifdef ALU_SEQ_DIV_EN
         div_q <= div_d;
         rem_q <= rem_d;
`endif
      end
   end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU, single-cycle logic/add/sub/slt, iterative MUL.
// Define ALU_SEQ_DIV_EN to add iterative DIVU/REMU.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic   clk_i,
   input  logic   rst_i,
   alu_seq_if.slave bus
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] alu_res;
   logic             start;
   logic             iter_done;
   logic [WIDTH-1:0] iter_res;

   always_comb begin
      alu_res = '0;
      unique case (bus.ctrl_i)
         OP_AND:  alu_res = bus.src1_i & bus.src2_i;
         OP_OR:   alu_res = bus.src1_i | bus.src2_i;
         OP_ADD:  alu_res = bus.src1_i + bus.src2_i;
         OP_SUB:  alu_res = bus.src1_i - bus.src2_i;
         OP_SLT:  alu_res = WIDTH'(bus.src1_i < bus.src2_i);
         OP_NOR:  alu_res = ~(bus.src1_i | bus.src2_i);
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      start    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.valid_i) begin
               if (is_iter(bus.ctrl_i)) begin
                  start   = 1'b1;
                  state_d = BUSY;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  state_d  = DONE;
               end
            end
         end
         BUSY: begin
            if (iter_done) begin
               result_d = iter_res;
               zero_d   = (iter_res == '0);
               state_d  = DONE;
            end
         end
         DONE: begin
            if (bus.ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   alu_seq_iter #(
      .WIDTH (WIDTH)
   ) u_iter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start),
`ifdef ALU_SEQ_DIV_EN
      .op_i    (bus.ctrl_i),
`endif
      .a_i     (bus.src1_i),
      .b_i     (bus.src2_i),
      .done_o  (iter_done),
      .res_o   (iter_res)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.ready_o  = (state_q == IDLE);
   assign bus.valid_o  = (state_q == DONE);
   assign bus.result_o = result_q;
   assign bus.zero_o   = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// alu_seq bench: directed vector table, reset corner cases and random ops
// against an arithmetic reference model.
module tb_alu_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   last_acc = 0;

   alu_seq_if #(.WIDTH(32)) bus ();

   alu_seq #(.WIDTH(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      int          hold;
      bit          gap;
      string       nm;
   } vec_t;

   vec_t tbl[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit iter_op(input logic [3:0] op);
`ifdef ALU_SEQ_DIV_EN
      return op == 4'd8 || op == 4'd10 || op == 4'd11;
`else
      return op == 4'd8;
`endif
   endfunction

   function automatic logic [31:0] model(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      case (op)
         4'd0: return a & b;
         4'd1: return a | b;
         4'd2: return a + b;
         4'd5: return ~(a | b);
         4'd6: return a - b;
         4'd7: return (a < b) ? 32'd1 : 32'd0;
         4'd8: begin
            p = 64'(a) * 64'(b);
            return p[31:0];
         end
`ifdef ALU_SEQ_DIV_EN
         4'd10: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         4'd11: return (b == 0) ? a : a % b;
`endif
         default: return 32'd0;
      endcase
   endfunction

   task automatic add(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input int lat, input int hold,
                      input bit gap, input string nm);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp = exp;
      v.lat = lat; v.hold = hold; v.gap = gap; v.nm = nm;
      tbl.push_back(v);
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input int hold,
                         input bit gap, input string nm);
      int n;
      int w;
      logic [31:0] held;
      w = 0;
      while (!bus.ready_o && w < 100) begin
         tick();
         w++;
      end
      chk({nm, " ready_wait"}, 64'(bus.ready_o), 64'd1);
      bus.ctrl_i  = op;
      bus.src1_i  = a;
      bus.src2_i  = b;
      bus.valid_i = 1'b1;
      bus.ready_i = 1'b0;
      tick();
      if (gap) chk({nm, " accept_gap"}, 64'(cyc - last_acc), 64'd2);
      last_acc = cyc;
      bus.valid_i = 1'b0;
      bus.src1_i  = $urandom;
      bus.src2_i  = $urandom;
      n = 1;
      while (!bus.valid_o && n < 200) begin
         chk({nm, " busy_ready"}, 64'(bus.ready_o), 64'd0);
         bus.valid_i = 1'b1;
         bus.ctrl_i  = 4'(($urandom_range(0, 1) == 0) ? 2 : 8);
         bus.src1_i  = $urandom;
         tick();
         n++;
      end
      bus.valid_i = 1'b0;
      chk({nm, " latency"}, 64'(n), 64'(lat));
      chk({nm, " result"}, 64'(bus.result_o), 64'(exp));
      chk({nm, " zero"}, 64'(bus.zero_o), 64'(exp == 32'd0));
      held = exp;
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({nm, " hold_valid"}, 64'(bus.valid_o), 64'd1);
         chk({nm, " hold_result"}, 64'(bus.result_o), 64'(held));
         chk({nm, " hold_ready"}, 64'(bus.ready_o), 64'd0);
      end
      bus.ready_i = 1'b1;
      tick();
      bus.ready_i = 1'b0;
      chk({nm, " post_valid"}, 64'(bus.valid_o), 64'd0);
      chk({nm, " post_ready"}, 64'(bus.ready_o), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      bus.src1_i  = '0;
      bus.src2_i  = '0;
      bus.ctrl_i  = '0;

      add(4'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0, 1'b0, "add_wrap");
      add(4'd6, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0, 1'b1, "sub");
      add(4'd7, 32'd3, 32'hFFFF_FFFF, 32'd1, 1, 0, 1'b1, "slt");
      add(4'd5, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, 0, 1'b1, "nor");
      add(4'd8, 32'd7, 32'd6, 32'd42, 33, 0, 1'b0, "mul_7x6");
      add(4'd8, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 0, 1'b0, "mul_big");
      add(4'd2, 32'd1, 32'd2, 32'd3, 1, 5, 1'b0, "add_bp");
      add(4'd1, 32'hF0, 32'h0F, 32'hFF, 1, 0, 1'b0, "or");
      add(4'd7, 32'd7, 32'd3, 32'd0, 1, 0, 1'b0, "slt_false");
      add(4'd3, 32'd9, 32'd3, 32'd0, 1, 0, 1'b0, "undef_3");
`ifdef ALU_SEQ_DIV_EN
      add(4'd10, 32'd100, 32'd7, 32'd14, 33, 0, 1'b0, "divu");
      add(4'd11, 32'd100, 32'd7, 32'd2, 33, 0, 1'b0, "remu");
      add(4'd10, 32'd9, 32'd0, 32'hFFFF_FFFF, 33, 0, 1'b0, "divu_0");
      add(4'd11, 32'd9, 32'd0, 32'd9, 33, 0, 1'b0, "remu_0");
`else
      add(4'd10, 32'd100, 32'd7, 32'd0, 1, 0, 1'b0, "op1010_undef");
      add(4'd11, 32'd100, 32'd7, 32'd0, 1, 0, 1'b0, "op1011_undef");
`endif

      rst = 1'b1;
      tick();
      chk("rst_ready", 64'(bus.ready_o), 64'd1);
      tick();
      rst = 1'b0;
      chk("rst_valid", 64'(bus.valid_o), 64'd0);
      chk("rst_result", 64'(bus.result_o), 64'd0);
      chk("rst_zero", 64'(bus.zero_o), 64'd1);

      foreach (tbl[i])
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp,
                tbl[i].lat, tbl[i].hold, tbl[i].gap, tbl[i].nm);

      // reset partway through a multiply must abort it
      bus.ctrl_i  = 4'd8;
      bus.src1_i  = 32'd5;
      bus.src2_i  = 32'd3;
      bus.valid_i = 1'b1;
      tick();
      bus.valid_i = 1'b0;
      repeat (9) tick();
      chk("mid_mul_busy", 64'(bus.ready_o), 64'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort_valid", 64'(bus.valid_o), 64'd0);
      chk("abort_result", 64'(bus.result_o), 64'd0);
      chk("abort_zero", 64'(bus.zero_o), 64'd1);
      chk("abort_ready", 64'(bus.ready_o), 64'd1);
      repeat (40) tick();
      chk("abort_no_result", 64'(bus.valid_o), 64'd0);
      run_op(4'd0, 32'hF0, 32'h3C, 32'h30, 1, 0, 1'b0, "and_after_abort");

      for (int k = 0; k < 30; k++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
         run_op(op, a, b, model(op, a, b), iter_op(op) ? 33 : 1,
                $urandom_range(0, 2), 1'b0, $sformatf("rand%0d_op%0d", k, op));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the single-cycle ALU. It keeps the existing 4-bit operation encoding and adds a valid/ready interface on both sides. Logic operations, add, subtract and compare complete in one cycle. Multiply, and optionally divide, run over WIDTH cycles on an iterative datapath. It sits between the decode/register-read stage and writeback wherever a stall-capable execute unit is required.

## Interface
- WIDTH, 32: operand/result width in bits; legal range 4..64.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- valid_i  input  1  operands and ctrl_i valid this cycle.
- ready_o  output  1  block can accept an operation.
- src1_i  input  WIDTH  operand 1.
- src2_i  input  WIDTH  operand 2.
- ctrl_i  input  4  operation code.
- valid_o  output  1  result_o/zero_o hold a completed result.
- ready_i  input  1  consumer accepts the result.
- result_o  output  WIDTH  registered result.
- zero_o  output  1  registered, result_o == 0.

## Operation
- Opcodes (all unsigned):
  - 0000 AND
  - 0001 OR
  - 0010 ADD, mod 2^WIDTH
  - 0110 SUB, mod 2^WIDTH
  - 0111 SLT: 1 if src1 < src2, else 0
  - 0101 NOR
  - 1000 MUL: low WIDTH bits of the product, shift-add
  - any other code: result 0, single-cycle
- FSM states: IDLE, BUSY, DONE.
  - IDLE: ready_o=1. On valid_i&&ready_o, operands and opcode are latched.
  - From IDLE, single-cycle ops go to DONE with the result registered. Iterative ops go to BUSY with the counter set to WIDTH-1.
  - BUSY: ready_o=0. Processes one operand bit per cycle. When the counter reaches 0, writes result_o and goes to DONE.
  - DONE: valid_o=1 and result_o/zero_o are held stable. On ready_i, goes to IDLE.
- ready_o is 1 only in IDLE. There is no accept in DONE, so the fastest throughput is one op per 2 cycles.
- Inputs are ignored when valid_i&&ready_o is false. Operands may change freely after the accept cycle.
- Reset: state=IDLE, result_o=0, zero_o=1, valid_o=0, counter=0. ready_o reads 1 from the first cycle after reset.
  - Reset in BUSY or DONE aborts the operation; no result is produced.
  - Reset has priority over all handshakes in the same cycle.

## Timing
- Accept at cycle edge N, single-cycle op: valid_o=1 from N+1.
- Accept at N, MUL (and DIVU/REMU when configured): 1 cycle to load, WIDTH cycles in BUSY, valid_o=1 from N+WIDTH+1.
- Result handshake at edge M (valid_o&&ready_i): valid_o=0 and ready_o=1 from M+1.
- valid_o stays high and result_o stays unchanged for as long as ready_i is low.

## Configuration
- ALU_SEQ_DIV_EN, when defined:
  - Adds opcode 1010 DIVU (quotient) and 1011 REMU (remainder), unsigned restoring division with the same latency as MUL.
  - Divide by zero: DIVU gives all-ones, REMU gives src1. Same latency; no exception.
- When undefined: 1010 and 1011 behave like any other undefined code (result 0, single-cycle), and no divider hardware is built.

## Structure
- Package alu_seq_pkg holds the opcode localparams (OP_AND … OP_REMU) and the FSM state typedef (IDLE/BUSY/DONE).
- Sub-module alu_seq_iter holds the iterative datapath:
  - shift-add multiplier, plus the restoring divider under ALU_SEQ_DIV_EN
  - WIDTH-bit accumulator/remainder registers and the bit counter
  - start/done pulses to the parent FSM
- The parent holds the handshake FSM, the single-cycle combinational ops and the output registers.

## Test plan
- Reset, then ADD 0xFFFFFFFF+1, ready_i=1 -> valid_o at N+1, result_o=0, zero_o=1; ready_o=1 at N+2.
- SUB 5-7, then SLT 3,0xFFFFFFFF, then NOR 0,0 back-to-back -> 0xFFFFFFFE, 1, 0xFFFFFFFF; each accept exactly 2 cycles after the previous one.
- MUL 7*6, then MUL 0xFFFFFFFF*2 -> 42 and 0xFFFFFFFE, each with valid_o at accept+33; ready_o=0 throughout BUSY; valid_i asserted during BUSY is ignored.
- Backpressure: ADD 1+2 with ready_i low for 5 cycles -> valid_o=1 and result_o=3 stable for all 5 cycles; ready_o=0 until 1 cycle after ready_i rises.
- Reset asserted at cycle 10 of a MUL -> next cycle state IDLE, valid_o=0, result_o=0; a following AND 0xF0&0x3C returns 0x30.
- With ALU_SEQ_DIV_EN: DIVU 100/7=14, REMU 100%7=2, DIVU 9/0=0xFFFFFFFF, REMU 9%0=9, each at accept+33. Without the macro: opcode 1010 -> 0 at accept+1.
